l1_cache_ctrl: RTL

Direct-mapped L1 cache controller that sits directly upstream of `L1_tag_array`. It accepts one CPU request at a time and drives tag-array port A. It evaluates hit/miss on the registered tag read, and sequences dirty-victim writeback and line refill over a valid/ready memory interface, then writes the updated tag/valid/dirty back. Data-array control is derived from the same state machine.

---
 rtl/l1_cache_pkg.sv | 32 +++
 rtl/l1_sat_counter.sv | 36 +++
 rtl/l1_cache_ctrl.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/l1_cache_pkg.sv
// Shared types and address-field helpers for the direct-mapped L1 cache controller.
// Field widths describe the default 32-bit / 512-set / 32-byte-line geometry.
package l1_cache_pkg;

    localparam int unsigned ADDR_W   = 32;
    localparam int unsigned INDEX_W  = 9;
    localparam int unsigned OFFSET_W = 5;
    localparam int unsigned TAG_W    = ADDR_W - INDEX_W - OFFSET_W;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOOKUP  = 3'd1,
        S_WB_REQ  = 3'd2,
        S_WB_WAIT = 3'd3,
        S_RF_REQ  = 3'd4,
        S_RF_WAIT = 3'd5,
        S_FILL    = 3'd6
    } state_e;

    function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] a);
        return a[ADDR_W-1 -: TAG_W];
    endfunction

    function automatic logic [INDEX_W-1:0] addr_index(input logic [ADDR_W-1:0] a);
        return a[OFFSET_W +: INDEX_W];
    endfunction

    function automatic logic [OFFSET_W-1:0] addr_offset(input logic [ADDR_W-1:0] a);
        return a[OFFSET_W-1:0];
    endfunction

endpackage

// File: rtl/l1_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping; clr has priority over inc.
module l1_sat_counter
    import l1_cache_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + {{(WIDTH-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/l1_cache_ctrl.sv
// Direct-mapped L1 controller: drives tag-array port A, resolves hit/miss on the
// registered tag read, and sequences dirty writeback plus refill over the memory port.
module l1_cache_ctrl
    import l1_cache_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int TAG_BITS    = 18,
    parameter int INDEX_WIDTH = 9,
    parameter int OFFSET_BITS = 5
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cpu_req_valid,
    output logic                   cpu_req_ready,
    input  logic                   cpu_req_we,
    input  logic [ADDR_WIDTH-1:0]  cpu_req_addr,
    output logic                   cpu_resp_valid,
    output logic                   cpu_resp_hit,
    output logic [INDEX_WIDTH-1:0] tag_addr,
    output logic                   tag_we,
    output logic [TAG_BITS-1:0]    tag_wdata,
    output logic                   tag_valid_w,
    output logic                   tag_dirty_w,
    input  logic [TAG_BITS-1:0]    tag_q,
    input  logic                   tag_valid_q,
    input  logic                   tag_dirty_q,
    output logic                   mem_req_valid,
    input  logic                   mem_req_ready,
    output logic                   mem_req_we,
    output logic [ADDR_WIDTH-1:0]  mem_req_addr,
    input  logic                   mem_resp_valid,
    output logic                   data_fill_we,
    output logic [31:0]            miss_count,
    output logic [31:0]            wb_count
);

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   req_addr_q, req_addr_d;
    logic                    req_we_q, req_we_d;
    logic [TAG_BITS-1:0]     victim_tag_q, victim_tag_d;

    logic [TAG_BITS-1:0]     req_tag;
    logic [INDEX_WIDTH-1:0]  req_idx;
    logic [INDEX_WIDTH-1:0]  cpu_idx;
    logic                    lookup_hit;
    logic                    miss_inc;
    logic                    wb_inc;

    assign req_tag    = req_addr_q[ADDR_WIDTH-1 -: TAG_BITS];
    assign req_idx    = req_addr_q[OFFSET_BITS +: INDEX_WIDTH];
    assign cpu_idx    = cpu_req_addr[OFFSET_BITS +: INDEX_WIDTH];
    assign lookup_hit = tag_valid_q && (tag_q == req_tag);

    // Outputs are decoded from the registered state, so an async reset forces them low at once.
    always_comb begin
        state_d        = state_q;
        req_addr_d     = req_addr_q;
        req_we_d       = req_we_q;
        victim_tag_d   = victim_tag_q;
        cpu_req_ready  = 1'b0;
        cpu_resp_valid = 1'b0;
        cpu_resp_hit   = 1'b0;
        tag_addr       = req_idx;
        tag_we         = 1'b0;
        tag_wdata      = '0;
        tag_valid_w    = 1'b0;
        tag_dirty_w    = 1'b0;
        mem_req_valid  = 1'b0;
        mem_req_we     = 1'b0;
        mem_req_addr   = '0;
        data_fill_we   = 1'b0;
        miss_inc       = 1'b0;
        wb_inc         = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                cpu_req_ready = rst_n;
                tag_addr      = rst_n ? cpu_idx : '0;
                if (cpu_req_valid) begin
                    req_addr_d = cpu_req_addr;
                    req_we_d   = cpu_req_we;
                    state_d    = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                if (lookup_hit) begin
                    cpu_resp_valid = 1'b1;
                    cpu_resp_hit   = 1'b1;
                    if (req_we_q) begin
                        tag_we      = 1'b1;
                        tag_wdata   = req_tag;
                        tag_valid_w = 1'b1;
                        tag_dirty_w = 1'b1;
                    end
                    state_d = S_IDLE;
                end else begin
                    miss_inc = 1'b1;
                    if (tag_valid_q && tag_dirty_q) begin
                        victim_tag_d = tag_q;
                        state_d      = S_WB_REQ;
                    end else begin
                        state_d = S_RF_REQ;
                    end
                end
            end
            S_WB_REQ: begin
                mem_req_valid = 1'b1;
                mem_req_we    = 1'b1;
                mem_req_addr  = {victim_tag_q, req_idx, {OFFSET_BITS{1'b0}}};
                if (mem_req_ready) begin
                    wb_inc  = 1'b1;
                    state_d = S_WB_WAIT;
                end
            end
            S_WB_WAIT: begin
                if (mem_resp_valid) begin
                    state_d = S_RF_REQ;
                end
            end
            S_RF_REQ: begin
                mem_req_valid = 1'b1;
                mem_req_addr  = {req_tag, req_idx, {OFFSET_BITS{1'b0}}};
                if (mem_req_ready) begin
                    state_d = S_RF_WAIT;
                end
            end
            S_RF_WAIT: begin
                if (mem_resp_valid) begin
                    state_d = S_FILL;
                end
            end
            S_FILL: begin
                tag_we         = 1'b1;
                tag_wdata      = req_tag;
                tag_valid_w    = 1'b1;
                tag_dirty_w    = req_we_q;
                data_fill_we   = 1'b1;
                cpu_resp_valid = 1'b1;
                state_d        = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Request and victim fields are only consumed after IDLE reloads them, so they carry no reset.
    always_ff @(posedge clk) begin
        req_addr_q   <= req_addr_d;
        req_we_q     <= req_we_d;
        victim_tag_q <= victim_tag_d;
    end

    l1_sat_counter #(.WIDTH(32)) u_miss_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (miss_inc),
        .clr   (1'b0),
        .count (miss_count)
    );

    l1_sat_counter #(.WIDTH(32)) u_wb_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (wb_inc),
        .clr   (1'b0),
        .count (wb_count)
    );

endmodule
